address_sequencer: RTL

Parametrised, strided address generator for the block-memory datapath. It produces the next RAM address each time a processing stage signals completion, as the des-done or store-done pulses do. It adds a programmable end address, stride, wrap/stop mode, an advance-source vector of configurable width, and status outputs. It sits between the stage controllers and the RAM address mux.

---
 rtl/address_sequencer_if.sv | 31 +++
 rtl/address_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/address_sequencer_if.sv
// Bus between the stage controllers and the address sequencer: configuration,
// advance pulses and the registered status/address outputs.
interface address_sequencer_if #(
    parameter int ADDR_WIDTH = 17,
    parameter int STEP_WIDTH = 4,
    parameter int NUM_SRC    = 2
);
    logic                  load;
    logic [ADDR_WIDTH-1:0] startAddress;
    logic [ADDR_WIDTH-1:0] endAddress;
    logic [STEP_WIDTH-1:0] step;
    logic                  wrapMode;
    logic                  pause;
    logic [NUM_SRC-1:0]    advance;
    logic [ADDR_WIDTH-1:0] address;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic                  wrapped;
    logic [ADDR_WIDTH:0]   beatCount;

    modport master (
        output load, startAddress, endAddress, step, wrapMode, pause, advance,
        input  address, busy, done, error, wrapped, beatCount
    );

    modport slave (
        input  load, startAddress, endAddress, step, wrapMode, pause, advance,
        output address, busy, done, error, wrapped, beatCount
    );
endinterface

// File: rtl/address_sequencer.sv
// Strided RAM address generator. Each accepted completion pulse moves the
// address by the latched stride, clamping onto the end address so it is always
// visited, then either wraps back to start or stops.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | after reset; advances ignored until a load
// S_RUN  | walking the range; busy=1
// S_DONE | stop-mode run finished, or load rejected (start > end, error=1)
module address_sequencer #(
    parameter int ADDR_WIDTH = 17,
    parameter int STEP_WIDTH = 4,
    parameter int NUM_SRC    = 2
) (
    input  logic                 clock,
    input  logic                 resetN,
    address_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_start_reg;
    logic [ADDR_WIDTH-1:0] r_end_reg;
    logic [STEP_WIDTH-1:0] r_step_reg;
    logic                  r_mode_reg;
    logic [ADDR_WIDTH-1:0] r_address;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic                  r_wrapped;
    logic [ADDR_WIDTH:0]   r_beat_count;

    logic [NUM_SRC-1:0]    w_advance;
    logic                  w_accept;
    logic [STEP_WIDTH-1:0] w_step_eff;
    logic [ADDR_WIDTH:0]   w_next;
    logic [ADDR_WIDTH:0]   w_beat_next;

    // Advance qualification and next-address arithmetic; the extra bit in
    // w_next keeps a stride past the top of the address space from wrapping.
    assign w_advance   = bus.advance;
    assign w_accept    = (r_state == S_RUN) && (|w_advance) && !bus.pause;
    assign w_step_eff  = (bus.step == '0) ? STEP_WIDTH'(1) : bus.step;
    assign w_next      = {1'b0, r_address} + (ADDR_WIDTH+1)'(r_step_reg);
    assign w_beat_next = (&r_beat_count) ? r_beat_count
                                         : r_beat_count + (ADDR_WIDTH+1)'(1);

    // Sequencer state machine with all outputs registered; load wins over advance.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_start_reg  <= '0;
            r_end_reg    <= '0;
            r_step_reg   <= '0;
            r_mode_reg   <= 1'b0;
            r_address    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_wrapped    <= 1'b0;
            r_beat_count <= '0;
        end else if (bus.load) begin
            r_start_reg  <= bus.startAddress;
            r_end_reg    <= bus.endAddress;
            r_step_reg   <= w_step_eff;
            r_mode_reg   <= bus.wrapMode;
            r_address    <= bus.startAddress;
            r_beat_count <= '0;
            r_wrapped    <= 1'b0;
            if (bus.startAddress > bus.endAddress) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_error <= 1'b1;
            end else begin
                r_state <= S_RUN;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_error <= 1'b0;
            end
        end else begin
            r_wrapped <= 1'b0;
            if (w_accept) begin
                r_beat_count <= w_beat_next;
                if (r_address == r_end_reg) begin
                    if (r_mode_reg) begin
                        r_address <= r_start_reg;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end else if (w_next > {1'b0, r_end_reg}) begin
                    r_address <= r_end_reg;
                end else begin
                    r_address <= w_next[ADDR_WIDTH-1:0];
                end
            end
        end
    end

    assign bus.address   = r_address;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.error     = r_error;
    assign bus.wrapped   = r_wrapped;
    assign bus.beatCount = r_beat_count;

endmodule
